// File: rtl/life_cell_engine_if.sv
// Walker-to-engine address handshake: one (row, col) per addr_valid & addr_ready,
// plus the walker's end-of-grid indication.
interface life_cell_engine_if #(
  parameter int ADDR_W = 7
);
  logic              addr_valid;
  logic [ADDR_W-1:0] addrR;
  logic [ADDR_W-1:0] addrC;
  logic              addr_ready;
  logic              walk_done;

  modport master (output addr_valid, addrR, addrC, walk_done, input addr_ready);
  modport slave  (input addr_valid, addrR, addrC, walk_done, output addr_ready);
endinterface

// File: rtl/life_cell_engine.sv
// Game of Life cell engine: reads a 3x3 neighbourhood, applies the rule, writes next generation.
// Define LIFE_TORUS_EN for a wrap-around grid; otherwise off-grid neighbours read as dead.
module life_cell_engine #(
  parameter int ADDR_W = 7,
  parameter int GRID_R = 128,
  parameter int GRID_C = 128,
  parameter int CNT_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  life_cell_engine_if.slave walk,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addrR,
  output logic [ADDR_W-1:0] rd_addrC,
  input  logic              rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addrR,
  output logic [ADDR_W-1:0] wr_addrC,
  output logic              wr_data,
  output logic              busy,
  output logic [CNT_W-1:0]  live_cnt,
  output logic              gen_done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t            state_q;
  logic [3:0]        k_q;
  logic              addr_ready_q, rd_en_q, wr_en_q, wr_data_q, busy_q, gen_done_q, done_q;
  logic [ADDR_W-1:0] rd_r_q, rd_c_q, wr_r_q, wr_c_q;
  logic [CNT_W-1:0]  live_cnt_q;
  logic [3:0]        n_q;
  logic              alive_q;
  logic              vld_p0, live_p0, ctr_p0;
  logic              vld_p1, live_p1, ctr_p1;

  logic              accept_d, issue_d, ok_r_d, ok_c_d, nb_ok_d;
  logic [3:0]        fetch_k_d;
  logic [ADDR_W-1:0] base_r_d, base_c_d, nb_r_d, nb_c_d;
  logic              smp_bit_d, alive_d, rule_d, in_range_d;
  logic [3:0]        n_d;

  // Returns {on_grid, coord} for base + (off - 1) along one axis of length lim.
  function automatic logic [ADDR_W:0] nb_coord(input logic [ADDR_W-1:0] base,
                                               input int off, input int lim);
    int  v;
    logic ok;
    v = int'(base) + off - 1;
`ifdef LIFE_TORUS_EN
    if (v < 0) v = v + lim;
    else if (v >= lim) v = v - lim;
    ok = 1'b1;
`else
    ok = (v >= 0) && (v < lim);
`endif
    return {ok, ADDR_W'(v)};
  endfunction

  always_comb begin
    accept_d  = (state_q == IDLE) && addr_ready_q && walk.addr_valid;
    issue_d   = accept_d || ((state_q == FETCH) && (k_q != 4'd8));
    fetch_k_d = (state_q == IDLE) ? 4'd0 : k_q + 4'd1;
    base_r_d  = (state_q == IDLE) ? walk.addrR : wr_r_q;
    base_c_d  = (state_q == IDLE) ? walk.addrC : wr_c_q;
    {ok_r_d, nb_r_d} = nb_coord(base_r_d, int'(fetch_k_d) / 3, GRID_R);
    {ok_c_d, nb_c_d} = nb_coord(base_c_d, int'(fetch_k_d) % 3, GRID_C);
    nb_ok_d   = ok_r_d & ok_c_d;
    // Off-grid reads never strobed the RAM, so their sample is forced dead.
    smp_bit_d = live_p1 & rd_data;
    n_d       = n_q;
    alive_d   = alive_q;
    if (vld_p1) begin
      if (ctr_p1) alive_d = smp_bit_d;
      else        n_d     = n_q + {3'b000, smp_bit_d};
    end
    rule_d     = (n_d == 4'd3) | (alive_d & (n_d == 4'd2));
    in_range_d = (int'(wr_r_q) < GRID_R) && (int'(wr_c_q) < GRID_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 4'd0;
      addr_ready_q <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 1'b0;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      done_q       <= 1'b0;
      rd_r_q       <= '0;
      rd_c_q       <= '0;
      wr_r_q       <= '0;
      wr_c_q       <= '0;
      live_cnt_q   <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 1'b0;
      gen_done_q <= 1'b0;
      done_q     <= done_q | walk.walk_done;
      if (gen_done_q) live_cnt_q <= '0;
      // p0: read strobed this cycle; p1: its RAM data is on rd_data
      vld_p0  <= 1'b0;
      vld_p1  <= vld_p0;
      live_p1 <= live_p0;
      ctr_p1  <= ctr_p0;
      n_q     <= n_d;
      alive_q <= alive_d;
      if (issue_d) begin
        rd_en_q <= nb_ok_d;
        if (nb_ok_d) begin
          rd_r_q <= nb_r_d;
          rd_c_q <= nb_c_d;
        end
        vld_p0  <= 1'b1;
        live_p0 <= nb_ok_d;
        ctr_p0  <= (fetch_k_d == 4'd4);
      end
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q      <= FETCH;
            k_q          <= 4'd0;
            wr_r_q       <= walk.addrR;
            wr_c_q       <= walk.addrC;
            n_q          <= 4'd0;
            alive_q      <= 1'b0;
            addr_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end else begin
            addr_ready_q <= en;
            if (done_q && !walk.addr_valid) begin
              gen_done_q <= 1'b1;
              done_q     <= walk.walk_done;
            end
          end
        end
        FETCH: begin
          if (k_q == 4'd8) state_q <= DRAIN;
          else             k_q     <= fetch_k_d;
        end
        DRAIN: begin
          state_q   <= WRITE;
          wr_en_q   <= in_range_d;
          wr_data_q <= rule_d;
        end
        WRITE: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          addr_ready_q <= en;
          if (wr_en_q && wr_data_q) live_cnt_q <= live_cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign walk.addr_ready = addr_ready_q;
  assign rd_en    = rd_en_q;
  assign rd_addrR = rd_r_q;
  assign rd_addrC = rd_c_q;
  assign wr_en    = wr_en_q;
  assign wr_addrR = wr_r_q;
  assign wr_addrC = wr_c_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign live_cnt = live_cnt_q;
  assign gen_done = gen_done_q;

endmodule
